// File: rtl/freq_meter.sv
// Gated frequency meter: counts synchronized rising edges of meas_in over back-to-back windows.
// Optional consecutive-window lock filter is built only when FREQ_METER_LOCK_EN is defined.
module freq_meter #(
   parameter int GATE_CYCLES  = 27000,
   parameter int CNT_W        = 16,
   parameter int MIN_COUNT    = 0,
   parameter int MAX_COUNT    = 65534,
   parameter int LOCK_WINDOWS = 4
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic             meas_in,
   input  logic             enable,
   output logic [CNT_W-1:0] count,
   output logic             count_valid,
   output logic             in_range,
   output logic             overflow,
   output logic             locked
);

   localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
   localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   typedef enum logic {IDLE, GATE} state_t;

   state_t           state_q, state_d;
   logic             sync1_q, sync2_q, prev_q;
   logic [GW-1:0]    gate_q, gate_d;
   logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
   logic             ovf_q, ovf_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             valid_q, valid_d;
   logic             in_range_q, in_range_d;
   logic             overflow_q, overflow_d;

   logic             edge_det;
   logic [CNT_W-1:0] win_cnt;
   logic             win_ovf;
   logic             win_in_range;
   int               win_int;

   // prev follows the synchronizer in every state, so enabling while meas_in is high sees no edge
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= meas_in;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   assign edge_det     = sync2_q & ~prev_q;
   assign win_cnt      = (edge_det && (edge_cnt_q != CNT_MAX)) ? edge_cnt_q + 1'b1 : edge_cnt_q;
   assign win_ovf      = ovf_q | (win_cnt == CNT_MAX);
   assign win_int      = 32'(win_cnt);
   assign win_in_range = !win_ovf && (win_int >= MIN_COUNT) && (win_int <= MAX_COUNT);

   always_comb begin
      state_d    = state_q;
      gate_d     = gate_q;
      edge_cnt_d = edge_cnt_q;
      ovf_d      = ovf_q;
      count_d    = count_q;
      in_range_d = in_range_q;
      overflow_d = overflow_q;
      valid_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (enable) begin
               state_d    = GATE;
               gate_d     = '0;
               edge_cnt_d = '0;
               ovf_d      = 1'b0;
            end
         end
         GATE: begin
            if (!enable) begin
               state_d = IDLE;
            end else if (gate_q == GATE_LAST) begin
               // terminal cycle: publish the window (including this cycle's edge) and restart at once
               valid_d    = 1'b1;
               count_d    = win_cnt;
               overflow_d = win_ovf;
               in_range_d = win_in_range;
               gate_d     = '0;
               edge_cnt_d = '0;
               ovf_d      = 1'b0;
            end else begin
               gate_d     = gate_q + 1'b1;
               edge_cnt_d = win_cnt;
               ovf_d      = win_ovf;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q    <= IDLE;
         gate_q     <= '0;
         edge_cnt_q <= '0;
         ovf_q      <= 1'b0;
         count_q    <= '0;
         valid_q    <= 1'b0;
         in_range_q <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         gate_q     <= gate_d;
         edge_cnt_q <= edge_cnt_d;
         ovf_q      <= ovf_d;
         count_q    <= count_d;
         valid_q    <= valid_d;
         in_range_q <= in_range_d;
         overflow_q <= overflow_d;
      end
   end

   assign count       = count_q;
   assign count_valid = valid_q;
   assign in_range    = in_range_q;
   assign overflow    = overflow_q;

`ifdef FREQ_METER_LOCK_EN
   localparam int LW = (LOCK_WINDOWS > 0) ? $clog2(LOCK_WINDOWS + 1) : 1;
   localparam logic [LW-1:0] LOCK_TGT = LW'(LOCK_WINDOWS);

   logic [LW-1:0] lock_cnt_q, lock_cnt_d;
   logic          locked_q, locked_d;

   // dropping enable breaks the run of consecutive windows as well as the lock
   always_comb begin
      lock_cnt_d = lock_cnt_q;
      locked_d   = locked_q;
      if (!enable) begin
         lock_cnt_d = '0;
         locked_d   = 1'b0;
      end else if (valid_d) begin
         if (win_in_range) begin
            if (lock_cnt_q != LOCK_TGT) begin
               lock_cnt_d = lock_cnt_q + 1'b1;
            end
            locked_d = (lock_cnt_d == LOCK_TGT);
         end else begin
            lock_cnt_d = '0;
            locked_d   = 1'b0;
         end
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         lock_cnt_q <= '0;
         locked_q   <= 1'b0;
      end else begin
         lock_cnt_q <= lock_cnt_d;
         locked_q   <= locked_d;
      end
   end

   assign locked = locked_q;
`else
   assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: an 8-bit and a 4-bit counter instance share stimulus and are checked
// every cycle against a window-sum reference built from the recorded meas_in history.
module tb_freq_meter;

   localparam int G      = 100;
   localparam int MINC   = 24;
   localparam int MAXC   = 26;
   localparam int LOCK_N = 2;
`ifdef FREQ_METER_LOCK_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       meas_in = 1'b0;
   logic       enable = 1'b0;
   logic [7:0] count8;
   logic       v8, ir8, ov8, lk8;
   logic [3:0] count4;
   logic       v4, ir4, ov4, lk4;

   always #5 clk = ~clk;

   freq_meter #(.GATE_CYCLES(G), .CNT_W(8), .MIN_COUNT(MINC), .MAX_COUNT(MAXC),
                .LOCK_WINDOWS(LOCK_N)) dut8 (
      .sys_clk(clk), .sys_rst_n(rst_n), .meas_in(meas_in), .enable(enable),
      .count(count8), .count_valid(v8), .in_range(ir8), .overflow(ov8), .locked(lk8));

   freq_meter #(.GATE_CYCLES(G), .CNT_W(4), .MIN_COUNT(MINC), .MAX_COUNT(MAXC),
                .LOCK_WINDOWS(LOCK_N)) dut4 (
      .sys_clk(clk), .sys_rst_n(rst_n), .meas_in(meas_in), .enable(enable),
      .count(count4), .count_valid(v4), .in_range(ir4), .overflow(ov4), .locked(lk4));

   int checks = 0;
   int failures = 0;
   int cyc = 3;
   int ph = 0;
   bit hist_m [0:16383];

   // reference state: expected outputs, start cycle of the current enabled run, consecutive in-range windows
   int e_cnt8 = 0, e_cnt4 = 0;
   bit e_v = 0, e_ir8 = 0, e_ov8 = 0, e_ir4 = 0, e_ov4 = 0, e_lk = 0;
   int run_start = -1;
   int consec = 0;
   int strobes = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0d expected %0d at cycle %0d", tag, obs, exp, cyc);
      end
   endtask

   // an edge counted in the cycle ending at posedge m is a 0->1 step of meas_in sampled at m-3, m-2
   function automatic int rise(input int m);
      return int'(hist_m[m-2] & ~hist_m[m-3]);
   endfunction

   task automatic model_zero();
      e_cnt8 = 0; e_cnt4 = 0; e_v = 0; e_ir8 = 0; e_ov8 = 0; e_ir4 = 0; e_ov4 = 0; e_lk = 0;
      run_start = -1;
      consec = 0;
   endtask

   task automatic model_step();
      int raw;
      cyc++;
      hist_m[cyc] = rst_n ? meas_in : 1'b0;
      if (!rst_n) begin
         model_zero();
      end else if (!enable) begin
         e_v = 0; e_lk = 0; consec = 0; run_start = -1;
      end else if (run_start < 0) begin
         run_start = cyc;
         e_v = 0;
      end else if ((cyc - run_start) % G == 0) begin
         raw = 0;
         for (int m = cyc - G + 1; m <= cyc; m++) raw += rise(m);
         e_cnt8 = (raw > 255) ? 255 : raw;
         e_ov8  = (raw >= 255);
         e_ir8  = !e_ov8 && (raw >= MINC) && (raw <= MAXC);
         e_cnt4 = (raw > 15) ? 15 : raw;
         e_ov4  = (raw >= 15);
         e_ir4  = !e_ov4 && (raw >= MINC) && (raw <= MAXC);
         consec = e_ir8 ? consec + 1 : 0;
         e_lk   = LOCK_EN && (consec >= LOCK_N);
         e_v    = 1;
         strobes++;
      end else begin
         e_v = 0;
      end
   endtask

   task automatic check_all();
      chk("valid8", v8, e_v);
      chk("count8", count8, e_cnt8);
      chk("in_range8", ir8, e_ir8);
      chk("overflow8", ov8, e_ov8);
      chk("locked8", lk8, e_lk);
      chk("valid4", v4, e_v);
      chk("count4", count4, e_cnt4);
      chk("in_range4", ir4, e_ir4);
      chk("overflow4", ov4, e_ov4);
      chk("locked4", lk4, 1'b0);
   endtask

   task automatic tick(input bit m, input bit e);
      meas_in = m;
      enable  = e;
      @(posedge clk);
      model_step();
      @(negedge clk);
      if (e_v) $display("window cycle=%0d count8=%0d count4=%0d in_range=%0d ovf4=%0d locked=%0d",
                        cyc, count8, count4, ir8, ov4, lk8);
      check_all();
   endtask

   function automatic bit wave(input int per, input int hi);
      return (ph % per) >= (per - hi);
   endfunction

   task automatic run_strobes(input int per, input int hi, input int n);
      int target;
      int guard;
      target = strobes + n;
      guard = 0;
      while (strobes < target && guard < 400 * n) begin
         tick(wave(per, hi), 1'b1);
         ph++;
         guard++;
      end
      if (strobes < target) chk("strobe_timeout", strobes, target);
   endtask

   initial begin
      int k;
      int hold;
      int lvl_left;
      int en_off;
      bit lvl;

      @(negedge clk);
      for (int i = 0; i < 3; i++) tick(1'(i), 1'b0);
      chk("reset_count", count8, 0);
      chk("reset_valid", v8, 0);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) tick(1'(i % 2), 1'b0);

      // meas_in high while idle, enable arrives at the end of the high stretch
      for (int i = 0; i < 8; i++) tick(1'b1, 1'b0);
      ph = 0;
      run_strobes(4, 2, 1);
      chk("no_false_edge_count", count8, 25);

      run_strobes(4, 2, 2);
      chk("p4_count", count8, 25);
      chk("p4_in_range", ir8, 1);
      chk("p4_overflow", ov8, 0);
      chk("p4_locked", lk8, LOCK_EN);
      chk("sat_count4", count4, 15);
      chk("sat_overflow4", ov4, 1);
      chk("sat_in_range4", ir4, 0);

      run_strobes(5, 2, 2);
      chk("p5_count", count8, 20);
      chk("p5_in_range", ir8, 0);
      chk("p5_locked", lk8, 0);

      // abort a window half way, then re-enable
      run_strobes(4, 2, 1);
      hold = e_cnt8;
      for (int i = 0; i < 50; i++) begin tick(wave(4, 2), 1'b1); ph++; end
      for (int i = 0; i < 10; i++) begin tick(wave(4, 2), 1'b0); ph++; end
      chk("abort_hold_count", count8, hold);
      chk("abort_locked", lk8, 0);
      tick(wave(4, 2), 1'b1);
      ph++;
      k = 0;
      while (!v8 && k < 150) begin tick(wave(4, 2), 1'b1); ph++; k++; end
      chk("reenable_latency", k, 100);
      chk("reenable_count", count8, 25);

      // asynchronous reset in the middle of a window
      for (int i = 0; i < 40; i++) begin tick(wave(4, 2), 1'b1); ph++; end
      #2 rst_n = 1'b0;
      #1;
      chk("async_count", count8, 0);
      chk("async_valid", v8, 0);
      chk("async_in_range", ir8, 0);
      chk("async_overflow", ov8, 0);
      chk("async_locked", lk8, 0);
      chk("async_count4", count4, 0);
      model_zero();
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin tick(wave(4, 2), 1'b1); ph++; end
      rst_n = 1'b1;
      k = 0;
      while (!v8 && k < 150) begin tick(wave(4, 2), 1'b1); ph++; k++; end
      chk("post_reset_latency", k, 101);

      // random pulse widths around period 4 with occasional enable drops
      lvl = 1'b0;
      lvl_left = 0;
      en_off = 0;
      for (int i = 0; i < 1500; i++) begin
         if (lvl_left == 0) begin
            lvl = ~lvl;
            lvl_left = lvl ? 2 : int'($urandom_range(1, 3));
         end
         lvl_left--;
         if (en_off > 0) en_off--;
         else if ($urandom_range(0, 299) == 0) en_off = int'($urandom_range(1, 15));
         tick(lvl, en_off == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
